// File: rtl/camera_capture_ctrl_if.sv
// camera_capture_ctrl_if: frame-buffer write port (strobe, address, RGB332 data).
// Revision 1.0
`default_nettype none

interface camera_capture_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              W_EN;
  logic [ADDR_W-1:0] W_ADDR;
  logic [7:0]        W_DATA;

  modport master (output W_EN, W_ADDR, W_DATA);
  modport slave  (input  W_EN, W_ADDR, W_DATA);
endinterface

`default_nettype wire

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: OV7670 capture into a WIDTH x HEIGHT RGB332 frame buffer.
// Revision 1.0
`default_nettype none

module camera_capture_ctrl #(
  parameter int WIDTH  = 176,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  wire logic       CLOCK,
  input  wire logic       RESET_N,
  input  wire logic       CAM_PCLK,
  input  wire logic       CAM_HREF,
  input  wire logic       CAM_VSYNC,
  input  wire logic [7:0] CAM_DATA,
  input  wire logic       START,
  input  wire logic       CONTINUOUS,
  camera_capture_ctrl_if.master fb,
  output logic            BUSY,
  output logic            FRAME_DONE,
  output logic            TRUNCATED
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0]     c_WIDTH     = CW'(WIDTH);
  localparam logic [RW-1:0]     c_HEIGHT    = RW'(HEIGHT);
  localparam logic [ADDR_W-1:0] c_LINE_STEP = ADDR_W'(WIDTH);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ARM      = 2'd1;
  localparam logic [1:0] c_WAIT_SOF = 2'd2;
  localparam logic [1:0] c_CAPTURE  = 2'd3;

  logic r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic r_href_s1, r_href_s2, r_href_s3;
  logic r_vs_s1, r_vs_s2, r_vs_s3;
  logic [7:0] r_data_s1, r_data_s2, r_data_s3;
  logic r_pclk_rise, r_href_fall, r_vs_rise, r_vs_fall;

  logic              r_phase;
  logic [5:0]        r_b1;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_line_base;

  logic [1:0]        r_state, w_state_next;
  logic              r_w_en, r_busy, r_frame_done, r_truncated;
  logic [ADDR_W-1:0] r_w_addr;
  logic [7:0]        r_w_data;

  logic       w_start_acc, w_sof, w_eof, w_cap_active, w_in_range;
  logic       w_write, w_trunc, w_line_end, w_pix_edge;
  logic [7:0] w_pixel;

  // Edge pulses are registered, so r_data_s3/r_href_s3 line up with them.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_s3 <= 1'b0;
      r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_s3 <= 1'b0;
      r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_s3   <= 1'b0;
      r_data_s1 <= 8'h00; r_data_s2 <= 8'h00; r_data_s3 <= 8'h00;
      r_pclk_rise <= 1'b0; r_href_fall <= 1'b0;
      r_vs_rise   <= 1'b0; r_vs_fall   <= 1'b0;
    end else begin
      r_pclk_s1 <= CAM_PCLK;  r_pclk_s2 <= r_pclk_s1; r_pclk_s3 <= r_pclk_s2;
      r_href_s1 <= CAM_HREF;  r_href_s2 <= r_href_s1; r_href_s3 <= r_href_s2;
      r_vs_s1   <= CAM_VSYNC; r_vs_s2   <= r_vs_s1;   r_vs_s3   <= r_vs_s2;
      r_data_s1 <= CAM_DATA;  r_data_s2 <= r_data_s1; r_data_s3 <= r_data_s2;
      r_pclk_rise <= r_pclk_s2 & ~r_pclk_s3;
      r_href_fall <= ~r_href_s2 & r_href_s3;
      r_vs_rise   <= r_vs_s2 & ~r_vs_s3;
      r_vs_fall   <= ~r_vs_s2 & r_vs_s3;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_phase <= 1'b0;
      r_b1    <= 6'h00;
    end else if (!r_href_s3) begin
      r_phase <= 1'b0;
    end else if (r_pclk_rise) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_b1 <= {r_data_s3[7:5], r_data_s3[2:0]};
    end
  end

  // RGB565 -> RGB332: R[4:2], G[5:3] from the first byte, B[4:3] from the second.
  assign w_pixel    = {r_b1, r_data_s3[4:3]};
  assign w_pix_edge = r_pclk_rise & r_href_s3 & r_phase;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= c_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:     if (START)     w_state_next = c_ARM;
      c_ARM:      if (r_vs_s3)   w_state_next = c_WAIT_SOF;
      c_WAIT_SOF: if (r_vs_fall) w_state_next = c_CAPTURE;
      c_CAPTURE:  if (r_vs_rise) w_state_next = CONTINUOUS ? c_WAIT_SOF : c_IDLE;
      default:                   w_state_next = c_IDLE;
    endcase
  end

  // End of frame masks any same-cycle line or pixel event.
  always_comb begin
    w_start_acc  = (r_state == c_IDLE) && START;
    w_sof        = (r_state == c_WAIT_SOF) && r_vs_fall;
    w_eof        = (r_state == c_CAPTURE) && r_vs_rise;
    w_cap_active = (r_state == c_CAPTURE) && !r_vs_rise;
    w_in_range   = (r_col < c_WIDTH) && (r_row < c_HEIGHT);
    w_write      = w_cap_active && w_pix_edge && w_in_range;
    w_trunc      = w_cap_active && w_pix_edge && !w_in_range;
    w_line_end   = w_cap_active && r_href_fall;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_col       <= '0;
      r_row       <= '0;
      r_line_base <= '0;
    end else if (w_sof) begin
      r_col       <= '0;
      r_row       <= '0;
      r_line_base <= '0;
    end else if (w_line_end) begin
      r_col <= '0;
      if (r_row < c_HEIGHT) begin
        r_row       <= r_row + RW'(1);
        r_line_base <= r_line_base + c_LINE_STEP;
      end
    end else if (w_write) begin
      r_col <= r_col + CW'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_w_en       <= 1'b0;
      r_w_addr     <= '0;
      r_w_data     <= 8'h00;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_truncated  <= 1'b0;
    end else begin
      r_w_en       <= w_write;
      r_busy       <= (w_state_next != c_IDLE);
      r_frame_done <= w_eof;
      if (w_write) begin
        r_w_addr <= r_line_base + ADDR_W'(r_col);
        r_w_data <= w_pixel;
      end
      if (w_start_acc)  r_truncated <= 1'b0;
      else if (w_trunc) r_truncated <= 1'b1;
    end
  end

  assign fb.W_EN     = r_w_en;
  assign fb.W_ADDR   = r_w_addr;
  assign fb.W_DATA   = r_w_data;
  assign BUSY        = r_busy;
  assign FRAME_DONE  = r_frame_done;
  assign TRUNCATED   = r_truncated;

endmodule

`default_nettype wire

// File: tb/tb_camera_capture_ctrl.sv
// tb_camera_capture_ctrl: directed camera frames on a reduced 8x6 buffer with a write scoreboard.
// Revision 1.0
`default_nettype none

module tb_camera_capture_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 6;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CAM_PCLK = 1'b0, CAM_HREF = 1'b0, CAM_VSYNC = 1'b0;
  logic [7:0] CAM_DATA = 8'h00;
  logic       START = 1'b0, CONTINUOUS = 1'b0;
  logic       BUSY, FRAME_DONE, TRUNCATED;

  camera_capture_ctrl_if #(.ADDR_W(AW)) fb ();

  camera_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF), .CAM_VSYNC(CAM_VSYNC), .CAM_DATA(CAM_DATA),
    .START(START), .CONTINUOUS(CONTINUOUS),
    .fb(fb),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .TRUNCATED(TRUNCATED)
  );

  always #10 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_seen = 0;
  logic prev_wen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin : monitor
    wr_t e;
    if (RESET_N) begin
      if (FRAME_DONE) fd_seen++;
      if (fb.W_EN) begin
        check("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", fb.W_ADDR, fb.W_DATA);
        end else begin
          e = exp_q.pop_front();
          check("w_addr", {26'd0, fb.W_ADDR}, {26'd0, e.addr});
          check("w_data", {24'd0, fb.W_DATA}, {24'd0, e.data});
        end
      end
      prev_wen = fb.W_EN;
    end else begin
      prev_wen = 1'b0;
    end
  end

  function automatic logic [7:0] pack(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // PCLK at CLOCK/4: two cycles low with the byte set up, then two cycles high.
  task automatic send_byte(input logic [7:0] b);
    CAM_DATA = b;
    CAM_PCLK = 1'b0;
    tick(2);
    CAM_PCLK = 1'b1;
    tick(2);
    CAM_PCLK = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2, input bit exp_wr,
                            input logic [AW-1:0] addr, input logic [7:0] d);
    wr_t e;
    if (exp_wr) begin
      e.addr = addr;
      e.data = d;
      exp_q.push_back(e);
    end
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic send_line(input int row, input int npix, input bit cap, input bit special);
    CAM_HREF = 1'b1;
    tick(2);
    for (int c = 0; c < npix; c++) begin
      logic [7:0] b1, b2, d;
      b1 = 8'(row * 29 + c * 7 + 3);
      b2 = 8'(c * 13 + row * 5 + 1);
      d  = pack(b1, b2);
      if (special && c == 0) begin b1 = 8'hE5; b2 = 8'h38; d = 8'hF7; end
      if (special && c == 1) begin b1 = 8'h1F; b2 = 8'hFF; d = 8'h1F; end
      send_pixel(b1, b2, cap && c < W && row < H, AW'(row * W + c), d);
    end
    tick(2);
    CAM_HREF = 1'b0;
    tick(6);
  endtask

  task automatic frame_begin();
    CAM_VSYNC = 1'b1;
    tick(8);
    CAM_VSYNC = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    CAM_VSYNC = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input int nlines, input int npix, input bit cap, input bit special);
    frame_begin();
    for (int r = 0; r < nlines; r++) send_line(r, npix, cap, special && r == 0);
    frame_end();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick(1);
    START = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    tick(3);
    check("rst_busy", {31'd0, BUSY}, 0);
    check("rst_wen", {31'd0, fb.W_EN}, 0);
    check("rst_waddr", {26'd0, fb.W_ADDR}, 0);
    check("rst_wdata", {24'd0, fb.W_DATA}, 0);
    check("rst_frame_done", {31'd0, FRAME_DONE}, 0);
    check("rst_truncated", {31'd0, TRUNCATED}, 0);
    RESET_N = 1'b1;
    tick(2);

    // Single-shot frame, first line carries the packing vectors.
    pulse_start();
    check("busy_after_start", {31'd0, BUSY}, 1);
    send_frame(H, W, 1'b1, 1'b1);
    wait_drain("single_drain");
    check("single_fd", fd_seen, 1);
    check("single_busy", {31'd0, BUSY}, 0);
    check("single_trunc", {31'd0, TRUNCATED}, 0);

    // START during line 2 waits for the next full frame.
    frame_begin();
    for (int r = 0; r < H; r++) begin
      if (r == 2) pulse_start();
      send_line(r, W, 1'b0, 1'b0);
    end
    frame_end();
    check("midstart_busy", {31'd0, BUSY}, 1);
    check("midstart_fd", fd_seen, 1);
    send_frame(H, W, 1'b1, 1'b0);
    wait_drain("midstart_drain");
    check("midstart_fd2", fd_seen, 2);
    check("midstart_idle", {31'd0, BUSY}, 0);

    // Oversize frame; a START while busy must not clear TRUNCATED.
    pulse_start();
    frame_begin();
    for (int r = 0; r < H + 2; r++) begin
      if (r == H + 1) begin
        check("over_trunc_mid", {31'd0, TRUNCATED}, 1);
        pulse_start();
        tick(2);
        check("over_start_busy_ignored", {31'd0, TRUNCATED}, 1);
      end
      send_line(r, W + 2, 1'b1, 1'b0);
    end
    frame_end();
    wait_drain("over_drain");
    check("over_trunc", {31'd0, TRUNCATED}, 1);
    check("over_idle", {31'd0, BUSY}, 0);
    check("over_fd", fd_seen, 3);

    // Continuous: three frames, second one short, CONTINUOUS dropped in the third.
    CONTINUOUS = 1'b1;
    pulse_start();
    check("start_clears_trunc", {31'd0, TRUNCATED}, 0);
    send_frame(H, W, 1'b1, 1'b0);
    wait_drain("cont1_drain");
    check("cont1_fd", fd_seen, 4);
    check("cont1_busy", {31'd0, BUSY}, 1);
    send_frame(H - 2, W - 3, 1'b1, 1'b0);
    wait_drain("cont2_drain");
    check("cont2_fd", fd_seen, 5);
    check("cont2_busy", {31'd0, BUSY}, 1);
    frame_begin();
    for (int r = 0; r < H; r++) begin
      if (r == 3) CONTINUOUS = 1'b0;
      send_line(r, W, 1'b1, 1'b0);
    end
    frame_end();
    wait_drain("cont3_drain");
    check("cont3_fd", fd_seen, 6);
    check("cont3_idle", {31'd0, BUSY}, 0);
    check("cont_trunc", {31'd0, TRUNCATED}, 0);

    // Asynchronous reset partway through line 1.
    pulse_start();
    frame_begin();
    send_line(0, W, 1'b1, 1'b0);
    CAM_HREF = 1'b1;
    tick(2);
    for (int c = 0; c < 3; c++)
      send_pixel(8'(c + 8'h40), 8'(c * 8), 1'b1, AW'(W + c), pack(8'(c + 8'h40), 8'(c * 8)));
    tick(6);
    check("prereset_drain", exp_q.size(), 0);
    check("prereset_busy", {31'd0, BUSY}, 1);
    #5 RESET_N = 1'b0;
    #1;
    check("midrst_busy", {31'd0, BUSY}, 0);
    check("midrst_wen", {31'd0, fb.W_EN}, 0);
    check("midrst_waddr", {26'd0, fb.W_ADDR}, 0);
    check("midrst_wdata", {24'd0, fb.W_DATA}, 0);
    check("midrst_fd", {31'd0, FRAME_DONE}, 0);
    check("midrst_trunc", {31'd0, TRUNCATED}, 0);
    exp_q.delete();
    CAM_HREF = 1'b0;
    CAM_PCLK = 1'b0;
    CAM_VSYNC = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    tick(2);
    pulse_start();
    send_frame(H, W, 1'b1, 1'b0);
    wait_drain("postrst_drain");
    check("postrst_fd", fd_seen, 7);
    check("postrst_idle", {31'd0, BUSY}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
